// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals of mem_port_arbiter.
// The slave modport is the arbiter's view, and the master modport is the environment's view.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_ce;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_ce, m_we, m_be, m_addr, m_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_ce, m_we, m_be, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store. Data wins by default.
// A starvation counter forces a fetch grant after STARVE_MAX consecutive fetch losses.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          own_if_q, own_if_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          fetch_win;

  assign fetch_win = bus.if_req && (!bus.d_req || (starve_q == STARVE_LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      own_if_q <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      own_if_q <= own_if_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    own_if_d = own_if_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_d = CMD;
          if (fetch_win) begin
            own_if_d = 1'b1;
            we_d     = 1'b0;
            be_d     = '1;
            addr_d   = bus.if_addr;
            starve_d = '0;
          end else begin
            own_if_d = 1'b0;
            we_d     = bus.d_we;
            be_d     = bus.d_we ? bus.d_be : 4'hF;
            addr_d   = bus.d_addr;
            wdata_d  = bus.d_wdata;
            // A waiting fetch that loses accumulates; saturate so the forced win sticks.
            if (bus.if_req)
              starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
            else
              starve_d = '0;
          end
        end else begin
          starve_d = '0;
        end
      end
      CMD:     state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode registered state, so reset removes them asynchronously.
  assign bus.m_ce      = (state_q == CMD);
  assign bus.m_we      = (state_q == CMD) && we_q;
  assign bus.m_be      = (state_q == CMD) ? be_q : '0;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.if_gnt    = (state_q == CMD) && own_if_q;
  assign bus.d_gnt     = (state_q == CMD) && !own_if_q;
  assign bus.if_rvalid = (state_q == RESP) && own_if_q;
  assign bus.d_rvalid  = (state_q == RESP) && !own_if_q;
  assign bus.if_rdata  = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with STARVE_MAX=4 and one with STARVE_MAX=0.
// Stimulus pushes expected grant/response events, and per-instance monitors pop and compare them.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.AW(8), .DW(32)) bus_a ();
  mem_port_arbiter_if #(.AW(8), .DW(32)) bus_b ();

  mem_port_arbiter #(.AW(8), .DW(32), .STARVE_MAX(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mem_port_arbiter #(.AW(8), .DW(32), .STARVE_MAX(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    int         cyc;
    logic       ig, dg, ir, dr, ce, we;
    logic [3:0] be;
    logic [7:0] addr;
    logic [31:0] wdata, rdata;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];

  function automatic ev_t mk(int c, bit ig, bit dg, bit ir, bit dr, bit we, logic [3:0] be,
                             logic [7:0] addr, logic [31:0] wd, logic [31:0] rd);
    ev_t e;
    e.cyc = c; e.ig = ig; e.dg = dg; e.ir = ir; e.dr = dr; e.ce = ig | dg; e.we = we;
    e.be = be; e.addr = addr; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  function automatic bit ev_ok(ev_t e, ev_t a);
    bit ok;
    ok = (e.cyc == a.cyc) && (e.ig === a.ig) && (e.dg === a.dg) && (e.ir === a.ir) && (e.dr === a.dr);
    if (e.ig || e.dg)
      ok = ok && (a.ce === 1'b1) && (a.we === e.we) && (a.be === e.be) && (a.addr === e.addr)
              && (!e.we || (a.wdata === e.wdata));
    if (e.ir || e.dr)
      ok = ok && (a.rdata === e.rdata);
    return ok;
  endfunction

  task automatic report(string name, ev_t e, ev_t a);
    $display("FAIL %s got cyc=%0d ig=%b dg=%b ir=%b dr=%b ce=%b we=%b be=%h addr=%h wd=%h rd=%h want cyc=%0d ig=%b dg=%b ir=%b dr=%b we=%b be=%h addr=%h wd=%h rd=%h",
             name, a.cyc, a.ig, a.dg, a.ir, a.dr, a.ce, a.we, a.be, a.addr, a.wdata, a.rdata,
             e.cyc, e.ig, e.dg, e.ir, e.dr, e.we, e.be, e.addr, e.wdata, e.rdata);
  endtask

  function automatic ev_t sample(bit b);
    ev_t a;
    a.cyc = cyc;
    if (!b) begin
      a.ig = bus_a.if_gnt; a.dg = bus_a.d_gnt; a.ir = bus_a.if_rvalid; a.dr = bus_a.d_rvalid;
      a.ce = bus_a.m_ce; a.we = bus_a.m_we; a.be = bus_a.m_be; a.addr = bus_a.m_addr;
      a.wdata = bus_a.m_wdata; a.rdata = bus_a.if_rvalid ? bus_a.if_rdata : bus_a.d_rdata;
    end else begin
      a.ig = bus_b.if_gnt; a.dg = bus_b.d_gnt; a.ir = bus_b.if_rvalid; a.dr = bus_b.d_rvalid;
      a.ce = bus_b.m_ce; a.we = bus_b.m_we; a.be = bus_b.m_be; a.addr = bus_b.m_addr;
      a.wdata = bus_b.m_wdata; a.rdata = bus_b.if_rvalid ? bus_b.if_rdata : bus_b.d_rdata;
    end
    return a;
  endfunction

  initial begin : mon_a
    ev_t a, e;
    forever begin
      @(negedge clk);
      if (bus_a.if_gnt || bus_a.d_gnt || bus_a.if_rvalid || bus_a.d_rvalid) begin
        a = sample(1'b0);
        total++;
        if (qa.size() == 0) begin
          bad++;
          e = mk(-1, 0, 0, 0, 0, 0, 4'h0, 8'h00, '0, '0);
          report("unexpected_event_a", e, a);
        end else begin
          e = qa.pop_front();
          if (!ev_ok(e, a)) begin
            bad++;
            report("event_a", e, a);
          end
        end
      end
    end
  end

  initial begin : mon_b
    ev_t a, e;
    forever begin
      @(negedge clk);
      if (bus_b.if_gnt || bus_b.d_gnt || bus_b.if_rvalid || bus_b.d_rvalid) begin
        a = sample(1'b1);
        total++;
        if (qb.size() == 0) begin
          bad++;
          e = mk(-1, 0, 0, 0, 0, 0, 4'h0, 8'h00, '0, '0);
          report("unexpected_event_b", e, a);
        end else begin
          e = qb.pop_front();
          if (!ev_ok(e, a)) begin
            bad++;
            report("event_b", e, a);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Waits on negedges until n grants of instance b (0=A, 1=B) have been seen; returns on the last one.
  task automatic wait_gnts(input bit b, input int n, input string name);
    int seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!b && (bus_a.if_gnt || bus_a.d_gnt)) seen++;
      if (b && (bus_b.if_gnt || bus_b.d_gnt)) seen++;
      if (seen >= n) return;
    end
    total++;
    bad++;
    $display("FAIL %s timeout got=%0d grants want=%0d", name, seen, n);
  endtask

  task automatic start_cycle(output int c);
    @(posedge clk);
    #1;
    c = cyc;
  endtask

  initial begin : stim
    int c;
    bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = '0; bus_a.d_wdata = '0; bus_a.d_be = '0; bus_a.m_rdata = '0;
    bus_b.if_req = 0; bus_b.if_addr = '0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = '0; bus_b.d_wdata = '0; bus_b.d_be = '0; bus_b.m_rdata = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", {31'b0, bus_a.busy}, 32'd0);
    chk("reset_mce_mwe", {30'b0, bus_a.m_ce, bus_a.m_we}, 32'd0);
    chk("reset_gnt_rv", {28'b0, bus_a.if_gnt, bus_a.d_gnt, bus_a.if_rvalid, bus_a.d_rvalid}, 32'd0);
    chk("reset_mbe_addr", {20'b0, bus_a.m_be, bus_a.m_addr}, 32'd0);
    chk("reset_mwdata", bus_a.m_wdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fetch only
    start_cycle(c);
    bus_a.if_req = 1; bus_a.if_addr = 8'h10; bus_a.m_rdata = 32'h00500093;
    qa.push_back(mk(c + 1, 1, 0, 0, 0, 0, 4'hF, 8'h10, '0, '0));
    qa.push_back(mk(c + 2, 0, 0, 1, 0, 0, 4'h0, 8'h00, '0, 32'h00500093));
    wait_gnts(0, 1, "fetch_gnt");
    bus_a.if_req = 0;
    repeat (3) @(posedge clk);

    // Store
    start_cycle(c);
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 8'h20;
    bus_a.d_wdata = 32'hDEADBEEF; bus_a.d_be = 4'b0011;
    qa.push_back(mk(c + 1, 0, 1, 0, 0, 1, 4'b0011, 8'h20, 32'hDEADBEEF, '0));
    wait_gnts(0, 1, "store_gnt");
    bus_a.d_req = 0;
    chk("store_busy_cmd", {31'b0, bus_a.busy}, 32'd1);
    @(negedge clk);
    chk("store_busy_after", {31'b0, bus_a.busy}, 32'd0);
    repeat (2) @(posedge clk);

    // Load: byte enables forced to all-ones
    start_cycle(c);
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 8'h44; bus_a.d_be = 4'b0101;
    bus_a.m_rdata = 32'h000000FF;
    qa.push_back(mk(c + 1, 0, 1, 0, 0, 0, 4'hF, 8'h44, '0, '0));
    qa.push_back(mk(c + 2, 0, 0, 0, 1, 0, 4'h0, 8'h00, '0, 32'h000000FF));
    wait_gnts(0, 1, "load_gnt");
    bus_a.d_req = 0;
    repeat (3) @(posedge clk);

    // Both held: data x4, fetch on the 5th arbitration, repeated twice
    start_cycle(c);
    bus_a.if_req = 1; bus_a.if_addr = 8'h40;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 8'h30; bus_a.m_rdata = 32'h12345678;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        qa.push_back(mk(c + 1 + 3 * k, 1, 0, 0, 0, 0, 4'hF, 8'h40, '0, '0));
        qa.push_back(mk(c + 2 + 3 * k, 0, 0, 1, 0, 0, 4'h0, 8'h00, '0, 32'h12345678));
      end else begin
        qa.push_back(mk(c + 1 + 3 * k, 0, 1, 0, 0, 0, 4'hF, 8'h30, '0, '0));
        qa.push_back(mk(c + 2 + 3 * k, 0, 0, 0, 1, 0, 4'h0, 8'h00, '0, 32'h12345678));
      end
    end
    wait_gnts(0, 10, "starve_gnts");
    bus_a.if_req = 0; bus_a.d_req = 0;
    repeat (3) @(posedge clk);

    // STARVE_MAX=0: fetch wins twice while both held, then data alone
    start_cycle(c);
    bus_b.if_req = 1; bus_b.if_addr = 8'h08;
    bus_b.d_req = 1; bus_b.d_we = 0; bus_b.d_addr = 8'h90; bus_b.m_rdata = 32'hCAFE0001;
    qb.push_back(mk(c + 1, 1, 0, 0, 0, 0, 4'hF, 8'h08, '0, '0));
    qb.push_back(mk(c + 2, 0, 0, 1, 0, 0, 4'h0, 8'h00, '0, 32'hCAFE0001));
    qb.push_back(mk(c + 4, 1, 0, 0, 0, 0, 4'hF, 8'h08, '0, '0));
    qb.push_back(mk(c + 5, 0, 0, 1, 0, 0, 4'h0, 8'h00, '0, 32'hCAFE0001));
    qb.push_back(mk(c + 7, 0, 1, 0, 0, 0, 4'hF, 8'h90, '0, '0));
    qb.push_back(mk(c + 8, 0, 0, 0, 1, 0, 4'h0, 8'h00, '0, 32'hCAFE0001));
    wait_gnts(1, 2, "nostarve_fetch");
    bus_b.if_req = 0;
    wait_gnts(1, 1, "nostarve_data");
    bus_b.d_req = 0;
    repeat (3) @(posedge clk);

    // Reset during RESP of a load: rvalid never shows
    start_cycle(c);
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 8'h5C; bus_a.m_rdata = 32'hA5A5A5A5;
    qa.push_back(mk(c + 1, 0, 1, 0, 0, 0, 4'hF, 8'h5C, '0, '0));
    wait_gnts(0, 1, "rst_load_gnt");
    bus_a.d_req = 0;
    @(posedge clk);
    #1;
    chk("resp_busy_before_rst", {31'b0, bus_a.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus_a.busy}, 32'd0);
    chk("rst_rvalid_mce", {29'b0, bus_a.d_rvalid, bus_a.if_rvalid, bus_a.m_ce}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);

    // Fresh fetch after reset
    start_cycle(c);
    bus_a.if_req = 1; bus_a.if_addr = 8'h18; bus_a.m_rdata = 32'h00000013;
    qa.push_back(mk(c + 1, 1, 0, 0, 0, 0, 4'hF, 8'h18, '0, '0));
    qa.push_back(mk(c + 2, 0, 0, 1, 0, 0, 4'h0, 8'h00, '0, 32'h00000013));
    wait_gnts(0, 1, "post_rst_gnt");
    bus_a.if_req = 0;
    repeat (4) @(posedge clk);

    chk("queue_a_drained", qa.size(), 32'd0);
    chk("queue_b_drained", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
